// File: rtl/rc_arm_controller.sv
// -----------------------------------------------------------------------------
// rc_arm_controller
//
// Supervisory state machine between the PPM channel decoder and the
// attitude/mixer stage. It latches each decoded frame, tracks how long ago
// the last frame arrived, sequences the arm/disarm stick gestures and, when
// the radio link is lost while flying, runs a timed failsafe descent followed
// by a lockout that only clears once the pilot has the sticks in a safe
// position again. clk is the decoder's 1 MHz tick, so one cycle is 1 us.
//
// Ports
//   clk        in   system clock (1 MHz)
//   rst        in   asynchronous reset, active low
//   frame_stb  in   one-cycle pulse, ch_in holds a complete new frame
//   ch_in      in   6 x 12-bit decoded channels (0..999):
//                   0 roll, 1 pitch, 2 throttle, 3 yaw, 4 arm switch, 5 aux
//   ch_cmd     out  6 x 12-bit conditioned channel commands
//   armed      out  motors enabled (ARMED or DISARMING)
//   failsafe   out  failsafe descent active
//   state      out  current FSM state code
//   link_ok    out  a frame arrived within LINK_TIMEOUT cycles
// -----------------------------------------------------------------------------
module rc_arm_controller #(
  parameter int LINK_TIMEOUT = 50000,
  parameter int ARM_HOLD     = 1000000,
  parameter int FS_LAND      = 5000000,
  parameter int THR_LOW      = 50,
  parameter int STICK_HI     = 900,
  parameter int STICK_LO     = 100,
  parameter int SW_ON        = 500,
  parameter int FS_THR       = 300,
  parameter int CENTER       = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_stb,
  input  logic [11:0] ch_in  [0:5],
  output logic [11:0] ch_cmd [0:5],
  output logic        armed,
  output logic        failsafe,
  output logic [2:0]  state,
  output logic        link_ok
);

  localparam logic [2:0] S_DISARMED  = 3'd0;
  localparam logic [2:0] S_ARMING    = 3'd1;
  localparam logic [2:0] S_ARMED     = 3'd2;
  localparam logic [2:0] S_DISARMING = 3'd3;
  localparam logic [2:0] S_FAILSAFE  = 3'd4;
  localparam logic [2:0] S_LOCKOUT   = 3'd5;

  localparam int HOLD_W = (ARM_HOLD > 1) ? $clog2(ARM_HOLD) : 1;
  localparam int LAND_W = (FS_LAND  > 1) ? $clog2(FS_LAND)  : 1;

  localparam logic [15:0]       AGE_MAX   = 16'(LINK_TIMEOUT);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ARM_HOLD - 1);
  localparam logic [LAND_W-1:0] LAND_LAST = LAND_W'(FS_LAND - 1);

  localparam logic [11:0] THR_LOW_C  = 12'(THR_LOW);
  localparam logic [11:0] STICK_HI_C = 12'(STICK_HI);
  localparam logic [11:0] STICK_LO_C = 12'(STICK_LO);
  localparam logic [11:0] SW_ON_C    = 12'(SW_ON);
  localparam logic [11:0] FS_THR_C   = 12'(FS_THR);
  localparam logic [11:0] CENTER_C   = 12'(CENTER);

  logic [11:0]       snap_q   [0:5];
  logic [11:0]       ch_cmd_q [0:5];
  logic [11:0]       ch_cmd_d [0:5];
  logic [15:0]       age_q, age_d;
  logic              link_ok_q, link_ok_d;
  logic [2:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [LAND_W-1:0] land_q, land_d;
  logic              armed_q, armed_d;
  logic              failsafe_q, failsafe_d;

  // ---------------------------------------------------------------------------
  // Frame snapshot. Six flops, not a RAM: every element has a defined reset
  // value so downstream never sees stale sticks after a reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 6; i++) snap_q[i] <= '0;
    end else if (frame_stb) begin
      // NOTE: registers are always written with <= so every flop samples the
      // pre-edge value of every other flop, independent of statement order.
      for (int i = 0; i < 6; i++) snap_q[i] <= ch_in[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Frame-age counter. Reset starts it saturated so the link reads as lost
  // until the first frame arrives. link_ok is derived from the next age so a
  // strobe landing on the cycle the limit would be reached keeps it high.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (frame_stb)              age_d = '0;
    else if (age_q >= AGE_MAX)  age_d = AGE_MAX;
    else                        age_d = age_q + 16'd1;
    link_ok_d = (age_d < AGE_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age_q     <= AGE_MAX;
      link_ok_q <= 1'b0;
    end else begin
      age_q     <= age_d;
      link_ok_q <= link_ok_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Gesture predicates, evaluated on the snapshot only.
  // ---------------------------------------------------------------------------
  logic thr_low, arm_g, dis_g, sw_off;

  assign thr_low = (snap_q[2] < THR_LOW_C);
  assign arm_g   = thr_low && (snap_q[3] > STICK_HI_C) && (snap_q[4] > SW_ON_C);
  assign dis_g   = thr_low && (snap_q[3] < STICK_LO_C);
  assign sw_off  = (snap_q[4] <= SW_ON_C);

  // ---------------------------------------------------------------------------
  // Supervisory FSM. Timers only advance while the state that owns them is
  // active and the state leaves at terminal count, so they never wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    state_d = state_q;
    hold_d  = hold_q;
    land_d  = land_q;

    case (state_q)
      S_DISARMED: begin
        if (link_ok_q && arm_g) begin
          state_d = S_ARMING;
          hold_d  = '0;
        end
      end

      S_ARMING: begin
        if (!link_ok_q || !arm_g)    state_d = S_DISARMED;
        else if (hold_q == HOLD_LAST) state_d = S_ARMED;
        else                          hold_d  = hold_q + HOLD_W'(1);
      end

      // ARMED and DISARMING share the same priority: link loss beats the
      // kill switch, which beats the disarm gesture.
      S_ARMED, S_DISARMING: begin
        if (!link_ok_q) begin
          state_d = S_FAILSAFE;
          land_d  = '0;
        end else if (sw_off) begin
          state_d = S_DISARMED;
        end else if (state_q == S_ARMED) begin
          if (dis_g) begin
            state_d = S_DISARMING;
            hold_d  = '0;
          end
        end else if (!dis_g) begin
          state_d = S_ARMED;
        end else if (hold_q == HOLD_LAST) begin
          state_d = S_DISARMED;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      // The descent always runs to completion, even if the link recovers.
      S_FAILSAFE: begin
        if (land_q == LAND_LAST) state_d = S_LOCKOUT;
        else                     land_d  = land_q + LAND_W'(1);
      end

      S_LOCKOUT: begin
        if (link_ok_q && sw_off && thr_low) state_d = S_DISARMED;
      end

      // Unused codes fall back to the safe state.
      default: state_d = S_DISARMED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_DISARMED;
      hold_q  <= '0;
      land_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      land_q  <= land_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output conditioning, registered from the current state. Throttle is
  // forced to zero whenever the motors are not allowed to spin.
  // ---------------------------------------------------------------------------
  always_comb begin
    armed_d    = (state_q == S_ARMED) || (state_q == S_DISARMING);
    failsafe_d = (state_q == S_FAILSAFE);
    for (int i = 0; i < 6; i++) ch_cmd_d[i] = snap_q[i];

    case (state_q)
      S_ARMED, S_DISARMING: ;
      S_FAILSAFE: begin
        ch_cmd_d[0] = CENTER_C;
        ch_cmd_d[1] = CENTER_C;
        ch_cmd_d[2] = FS_THR_C;
        ch_cmd_d[3] = CENTER_C;
      end
      default: ch_cmd_d[2] = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q    <= 1'b0;
      failsafe_q <= 1'b0;
      for (int i = 0; i < 6; i++) ch_cmd_q[i] <= '0;
    end else begin
      armed_q    <= armed_d;
      failsafe_q <= failsafe_d;
      for (int i = 0; i < 6; i++) ch_cmd_q[i] <= ch_cmd_d[i];
    end
  end

  assign ch_cmd   = ch_cmd_q;
  assign armed    = armed_q;
  assign failsafe = failsafe_q;
  assign state    = state_q;
  assign link_ok  = link_ok_q;

endmodule

// File: tb/tb_rc_arm_controller.sv
// -----------------------------------------------------------------------------
// tb_rc_arm_controller
//
// Directed bench for rc_arm_controller with short timers (LINK_TIMEOUT=100,
// ARM_HOLD=20, FS_LAND=50). Inputs are driven and outputs sampled 1 time unit
// after each rising edge; periodic frames repeat the last frame sent every
// 50 cycles while frames_on is set.
// -----------------------------------------------------------------------------
module tb_rc_arm_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_stb;
  logic [11:0] ch_in  [0:5];
  logic [11:0] ch_cmd [0:5];
  logic [11:0] cur    [0:5];
  logic        armed;
  logic        failsafe;
  logic [2:0]  state;
  logic        link_ok;

  int n_checks = 0;
  int n_pass   = 0;
  bit frames_on = 1'b0;
  int since     = 0;
  int drops;

  rc_arm_controller #(
    .LINK_TIMEOUT(100),
    .ARM_HOLD    (20),
    .FS_LAND     (50)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .frame_stb(frame_stb),
    .ch_in    (ch_in),
    .ch_cmd   (ch_cmd),
    .armed    (armed),
    .failsafe (failsafe),
    .state    (state),
    .link_ok  (link_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock; injects the periodic frame when it is due.
  task automatic cyc();
    if (frames_on && since >= 49) begin
      ch_in     = cur;
      frame_stb = 1'b1;
      since     = 0;
    end else begin
      since++;
    end
    @(posedge clk);
    #1;
    frame_stb = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  // Send a frame on the next edge and make it the periodic frame.
  task automatic frame(input int c0, input int c1, input int c2,
                       input int c3, input int c4, input int c5);
    cur[0] = 12'(c0); cur[1] = 12'(c1); cur[2] = 12'(c2);
    cur[3] = 12'(c3); cur[4] = 12'(c4); cur[5] = 12'(c5);
    ch_in     = cur;
    frame_stb = 1'b1;
    since     = 0;
    @(posedge clk);
    #1;
    frame_stb = 1'b0;
  endtask

  // From DISARMED with link up: full arm gesture, ends one cycle after ARMED.
  task automatic arm_up();
    frame(410, 620, 10, 950, 800, 3);
    cycles(21);
    check("arm_up_state", int'(state), 2);
    cyc();
    check("arm_up_armed", int'(armed), 1);
  endtask

  initial begin
    rst       = 1'b0;
    frame_stb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ch_in[i] = '0;
      cur[i]   = '0;
    end

    // Reset state
    @(posedge clk);
    #1;
    check("rst_state",    int'(state),     0);
    check("rst_link",     int'(link_ok),   0);
    check("rst_armed",    int'(armed),     0);
    check("rst_failsafe", int'(failsafe),  0);
    check("rst_cmd0",     int'(ch_cmd[0]), 0);
    rst = 1'b1;
    cyc();
    check("idle_link", int'(link_ok), 0);

    // 1. First frame brings the link up; throttle held at zero while disarmed
    frames_on = 1'b1;
    frame(500, 500, 0, 500, 0, 0);
    check("t1_link",  int'(link_ok), 1);
    check("t1_state", int'(state),   0);
    cyc();
    check("t1_cmd0", int'(ch_cmd[0]), 500);
    check("t1_cmd2", int'(ch_cmd[2]), 0);

    // 6a. Strobe on the cycle the age would hit the limit keeps link up
    frames_on = 1'b0;
    frame(500, 500, 0, 500, 0, 0);
    drops = 0;
    repeat (99) begin
      cyc();
      if (!link_ok) drops++;
    end
    frame(500, 500, 0, 500, 0, 0);
    if (!link_ok) drops++;
    repeat (3) begin
      cyc();
      if (!link_ok) drops++;
    end
    check("t6_stb_wins", drops, 0);
    frames_on = 1'b1;

    // 2a. Arm gesture released at hold cycle 10 aborts
    frame(410, 620, 10, 950, 800, 3);
    cyc();
    check("t2_arming", int'(state), 1);
    cycles(9);
    frame(410, 620, 10, 500, 800, 3);
    check("t2_still_arming", int'(state), 1);
    cyc();
    check("t2_abort", int'(state), 0);
    cyc();
    check("t2_abort_armed", int'(armed), 0);

    // 2b. Full arm gesture: ARMED after 20 hold cycles, armed one cycle later
    frame(410, 620, 10, 950, 800, 3);
    cyc();
    check("t2_arming2", int'(state), 1);
    cycles(19);
    check("t2_hold19", int'(state), 1);
    cyc();
    check("t2_armed_state", int'(state), 2);
    check("t2_armed_lat",   int'(armed), 0);
    cyc();
    check("t2_armed", int'(armed), 1);

    // 3. Link loss while armed -> failsafe descent -> lockout
    frames_on = 1'b0;
    frame(410, 620, 10, 950, 800, 3);
    cycles(99);
    check("t3_link_pre", int'(link_ok), 1);
    cyc();
    check("t3_link_lost", int'(link_ok), 0);
    check("t3_still_armed", int'(state), 2);
    cyc();
    check("t3_fs_state", int'(state), 4);
    cyc();
    check("t3_failsafe", int'(failsafe),  1);
    check("t3_fs_armed", int'(armed),     0);
    check("t3_fs_cmd0",  int'(ch_cmd[0]), 500);
    check("t3_fs_cmd1",  int'(ch_cmd[1]), 500);
    check("t3_fs_cmd2",  int'(ch_cmd[2]), 300);
    check("t3_fs_cmd3",  int'(ch_cmd[3]), 500);
    check("t3_fs_cmd4",  int'(ch_cmd[4]), 800);
    check("t3_fs_cmd5",  int'(ch_cmd[5]), 3);
    cycles(18);
    frame(500, 500, 40, 500, 800, 7);
    check("t3_no_early_exit", int'(state),   4);
    check("t3_link_back",     int'(link_ok), 1);
    frames_on = 1'b1;
    cycles(29);
    check("t3_land_49", int'(state), 4);
    cyc();
    check("t3_lockout", int'(state), 5);
    cyc();
    check("t3_lo_failsafe", int'(failsafe),  0);
    check("t3_lo_armed",    int'(armed),     0);
    check("t3_lo_cmd2",     int'(ch_cmd[2]), 0);
    check("t3_lo_cmd4",     int'(ch_cmd[4]), 800);
    check("t3_lo_cmd5",     int'(ch_cmd[5]), 7);
    cycles(60);
    check("t3_lo_hold", int'(state), 5);
    frame(500, 500, 0, 500, 0, 0);
    check("t3_lo_pre_exit", int'(state), 5);
    cyc();
    check("t3_lo_exit", int'(state), 0);

    // 4. Kill switch while armed with throttle up
    arm_up();
    frame(500, 500, 900, 500, 800, 3);
    cyc();
    check("t4_armed_thr", int'(ch_cmd[2]), 900);
    frame(500, 500, 900, 500, 200, 3);
    check("t4_pre_kill", int'(state), 2);
    cyc();
    check("t4_kill", int'(state), 0);
    cyc();
    check("t4_kill_thr",   int'(ch_cmd[2]), 0);
    check("t4_kill_armed", int'(armed),     0);

    // 5a. Disarm gesture held for 20 cycles
    arm_up();
    frame(500, 500, 10, 20, 800, 3);
    check("t5_pre_dis", int'(state), 2);
    cyc();
    check("t5_disarming", int'(state), 3);
    cycles(19);
    check("t5_dis_hold19", int'(state), 3);
    check("t5_dis_armed",  int'(armed), 1);
    cyc();
    check("t5_disarmed", int'(state), 0);
    cyc();
    check("t5_dis_armed_off", int'(armed), 0);

    // 5b. Link loss beats a kill-switch frame arriving the same cycle
    arm_up();
    frames_on = 1'b0;
    frame(410, 620, 10, 950, 800, 3);
    cycles(100);
    check("t5_link_lost", int'(link_ok), 0);
    check("t5_armed_pre", int'(state),   2);
    frame(500, 500, 900, 500, 200, 3);
    check("t5_fs_priority", int'(state), 4);
    cyc();
    check("t5_fs_stays", int'(state),     4);
    check("t5_fs_flag",  int'(failsafe),  1);
    check("t5_fs_sw",    int'(ch_cmd[4]), 200);

    // 6b. Asynchronous reset in FAILSAFE, checked before any clock edge
    #2 rst = 1'b0;
    #1;
    check("t6_async_state",    int'(state),     0);
    check("t6_async_failsafe", int'(failsafe),  0);
    check("t6_async_armed",    int'(armed),     0);
    check("t6_async_link",     int'(link_ok),   0);
    check("t6_async_cmd4",     int'(ch_cmd[4]), 0);
    rst = 1'b1;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
